// File: rtl/serial_add_unit.sv
// serial_add_unit: digit-serial adder/subtractor, DIGIT bits per clock through one ripple slice and a carry flip-flop
module serial_add_unit #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             CLK_i,
   input  logic             Reset_L_i,
   input  logic             Start_i,
   input  logic             Sub_i,
   input  logic             Cin_i,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   output logic             Busy_o,
   output logic             Done_o,
   output logic [WIDTH-1:0] Sum_o,
   output logic             Cout_o,
   output logic             Overflow_o
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("serial_add_unit: DIGIT must divide WIDTH");
   end

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ps_q, ps_d, sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DIGIT:0]   dsum;
   logic [WIDTH-1:0] ps_next;
   logic             last;

   assign dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
   assign ps_next = WIDTH'({dsum[DIGIT-1:0], ps_q} >> DIGIT);
   assign last    = cnt_q == CW'(N - 1);

   // state and datapath registers, cleared asynchronously so a reset mid-operation leaves no result
   always_ff @(posedge CLK_i or negedge Reset_L_i) begin
      if (!Reset_L_i) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         ps_q    <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ps_q    <= ps_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   // load on Start outside ADD, otherwise step one digit per cycle and publish the result on the last digit
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      ps_d    = ps_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      if (Start_i && state_q != ADD) begin
         a_d     = A_i;
         b_d     = B_i ^ {WIDTH{Sub_i}};
         carry_d = Sub_i | Cin_i;
         cnt_d   = '0;
         state_d = ADD;
      end else if (state_q == ADD) begin
         a_d     = a_q >> DIGIT;
         b_d     = b_q >> DIGIT;
         ps_d    = ps_next;
         carry_d = dsum[DIGIT];
         cnt_d   = cnt_q + CW'(1);
         if (last) begin
            sum_d   = ps_next;
            cout_d  = dsum[DIGIT];
            ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (dsum[DIGIT-1] != a_q[DIGIT-1]);
            state_d = DONE;
         end
      end
   end

   assign Busy_o     = state_q == ADD;
   assign Done_o     = state_q == DONE;
   assign Sum_o      = sum_q;
   assign Cout_o     = cout_q;
   assign Overflow_o = ovf_q;
endmodule

// File: tb/tb_serial_add_unit.sv
// tb_serial_add_unit: directed and random checks of serial_add_unit (DIGIT=1 and DIGIT=4) against an arithmetic model
module tb_serial_add_unit;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start1, start4, sub, cin;
   logic [7:0] a, b;
   logic       busy1, done1, cout1, ovf1;
   logic       busy4, done4, cout4, ovf4;
   logic [7:0] sum1, sum4;
   int         n_assert = 0;
   int         n_fail = 0;
   logic [7:0] prev_sum [2];
   logic       prev_cout [2];
   logic       prev_ovf [2];

   serial_add_unit #(.WIDTH(8), .DIGIT(1)) dut1 (
      .CLK_i(clk), .Reset_L_i(rst_n), .Start_i(start1), .Sub_i(sub), .Cin_i(cin),
      .A_i(a), .B_i(b), .Busy_o(busy1), .Done_o(done1), .Sum_o(sum1),
      .Cout_o(cout1), .Overflow_o(ovf1)
   );

   serial_add_unit #(.WIDTH(8), .DIGIT(4)) dut4 (
      .CLK_i(clk), .Reset_L_i(rst_n), .Start_i(start4), .Sub_i(sub), .Cin_i(cin),
      .A_i(a), .B_i(b), .Busy_o(busy4), .Done_o(done4), .Sum_o(sum4),
      .Cout_o(cout4), .Overflow_o(ovf4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {overflow, cout, sum} from plain two's-complement arithmetic
   function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s, input logic c);
      logic [7:0] yp;
      int         t;
      logic [7:0] r;
      yp = s ? ~y : y;
      t  = int'(x) + int'(yp) + ((s || c) ? 1 : 0);
      r  = t[7:0];
      return {(x[7] == yp[7]) && (r[7] != x[7]), t[8], r};
   endfunction

   task automatic chk_idle(input int d, input string tag, input logic exp_done);
      chk({tag, " busy"}, d ? busy4 : busy1, 1'b0);
      chk({tag, " done"}, d ? done4 : done1, exp_done);
      chk({tag, " sum"},  d ? sum4  : sum1,  prev_sum[d]);
      chk({tag, " cout"}, d ? cout4 : cout1, prev_cout[d]);
      chk({tag, " ovf"},  d ? ovf4  : ovf1,  prev_ovf[d]);
   endtask

   // one operation on dut1 (d=0) or dut4 (d=1); intr>=0 pulses an ignored Start during that busy cycle
   task automatic op(input int d, input logic [7:0] x, input logic [7:0] y, input logic s, input logic c,
                     input int intr, input string tag);
      logic [9:0] e;
      int         n;
      e = model(x, y, s, c);
      n = d ? 2 : 8;
      @(negedge clk);
      a = x; b = y; sub = s; cin = c;
      if (d) start4 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      for (int i = 0; i < n; i++) begin
         chk({tag, " busy"}, d ? busy4 : busy1, 1'b1);
         chk({tag, " done"}, d ? done4 : done1, 1'b0);
         chk({tag, " hold sum"}, d ? sum4 : sum1, prev_sum[d]);
         if (i == intr) begin
            a = 8'hAA; b = 8'h55; sub = 1'($urandom);
            if (d) start4 = 1'b1; else start1 = 1'b1;
         end
         @(negedge clk);
         start1 = 1'b0; start4 = 1'b0;
      end
      prev_sum[d]  = e[7:0];
      prev_cout[d] = e[8];
      prev_ovf[d]  = e[9];
      chk_idle(d, tag, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
      for (int d = 0; d < 2; d++) begin
         prev_sum[d] = '0; prev_cout[d] = 1'b0; prev_ovf[d] = 1'b0;
      end
      repeat (2) @(negedge clk);
      chk_idle(0, "reset d1", 1'b0);
      chk_idle(1, "reset d4", 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle(0, "idle d1", 1'b0);

      op(0, 8'h00, 8'h00, 1'b0, 1'b0, -1, "zero");
      op(0, 8'hFF, 8'h01, 1'b0, 1'b0, -1, "ff+1");
      op(0, 8'h7F, 8'h01, 1'b0, 1'b0, -1, "7f+1");
      op(0, 8'h05, 8'h07, 1'b1, 1'b0, -1, "5-7");
      op(0, 8'h80, 8'h01, 1'b1, 1'b0, -1, "80-1");
      op(0, 8'h10, 8'h20, 1'b0, 1'b0, 2, "ignore start");
      op(0, 8'h03, 8'h04, 1'b0, 1'b1, -1, "from done");
      repeat (3) @(negedge clk);
      chk_idle(0, "done holds", 1'b1);

      @(negedge clk);
      a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         prev_sum[d] = '0; prev_cout[d] = 1'b0; prev_ovf[d] = 1'b0;
      end
      chk_idle(0, "async reset", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk({"post reset done"}, done1, 1'b0);
         chk({"post reset busy"}, busy1, 1'b0);
      end

      op(1, 8'h9C, 8'h77, 1'b0, 1'b1, -1, "d4 9c+77+1");
      op(1, 8'h80, 8'h01, 1'b1, 1'b0, -1, "d4 80-1");

      for (int k = 0; k < 20; k++)
         op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1, "rand d1");
      for (int k = 0; k < 12; k++)
         op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1, "rand d4");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
